lcd_refresh_scheduler: RTL and testbench

LCD_REFRESH_SCHEDULER -- requirements
Module: lcd_refresh_scheduler

---
 rtl/lcd_refresh_scheduler_if.sv | 48 ++++
 rtl/lcd_refresh_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_lcd_refresh_scheduler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_refresh_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_refresh_scheduler_if
// Description : Bundles the two frame-buffer write requesters and the HD44780
//               driver handshake of lcd_refresh_scheduler.
//               master : requester/driver side (drives req/addr/data, busy,
//                        read address; observes grants, trigger, read data,
//                        dirty flag and refresh count)
//               slave  : scheduler side
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_refresh_scheduler_if #(
    parameter int ADDR_W = 7
);
    // Requester A
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [7:0]        a_data;
    logic              a_gnt;
    // Requester B
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic [7:0]        b_data;
    logic              b_gnt;
    // HD44780 driver
    logic              lcd_busy;
    logic              lcd_trg;
    logic [ADDR_W-1:0] lcd_addr;
    logic [7:0]        lcd_data;
    // Status
    logic              dirty;
    logic [7:0]        refresh_cnt;

    modport master (
        output a_req, a_addr, a_data,
        output b_req, b_addr, b_data,
        output lcd_busy, lcd_addr,
        input  a_gnt, b_gnt, lcd_trg, lcd_data, dirty, refresh_cnt
    );

    modport slave (
        input  a_req, a_addr, a_data,
        input  b_req, b_addr, b_data,
        input  lcd_busy, lcd_addr,
        output a_gnt, b_gnt, lcd_trg, lcd_data, dirty, refresh_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lcd_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lcd_refresh_scheduler
// Description : Character frame buffer for a 4x20 HD44780 display. Two
//               requesters write characters through a round-robin arbiter;
//               whenever the buffer changes, the scheduler triggers the
//               driver to repaint, waits for it to finish, then enforces a
//               hold-off gap before the next repaint.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous, active-low reset
//               bus  - lcd_refresh_scheduler_if.slave (write requesters,
//                      driver trigger/busy/read port, dirty, refresh_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_refresh_scheduler #(
    parameter int MEM_DEPTH      = 80,
    parameter int ADDR_W         = 7,
    parameter int HOLDOFF_CYCLES = 25000,
    parameter int BUSY_TIMEOUT   = 16
) (
    input wire                     clk,
    input wire                     rst,
    lcd_refresh_scheduler_if.slave bus
);

    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int TO_W   = (BUSY_TIMEOUT   > 1) ? $clog2(BUSY_TIMEOUT)   : 1;

    localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [HOLD_W-1:0] c_HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [TO_W-1:0]   c_TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]        c_SPACE     = 8'h20;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_mem [MEM_DEPTH];
    logic [7:0]        r_lcd_data;
    logic              r_trg;
    logic              r_dirty;
    logic [7:0]        r_refresh_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_prio_b;      // 1: B wins the next contested cycle

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [7:0]        w_wr_data;
    logic              w_wr_en;
    logic              w_rd_in_range;
    logic              w_timeout;
    logic              w_done;

    // ------------------------------------------------------------------
    // Write arbitration: an uncontested request wins outright; on a
    // contest the requester granted most recently loses.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (bus.a_req && bus.b_req) begin
            if (r_prio_b) begin
                w_b_gnt = 1'b1;
            end else begin
                w_a_gnt = 1'b1;
            end
        end else begin
            w_a_gnt = bus.a_req;
            w_b_gnt = bus.b_req;
        end
    end

    assign w_wr_addr = w_b_gnt ? bus.b_addr : bus.a_addr;
    assign w_wr_data = w_b_gnt ? bus.b_data : bus.a_data;
    // Out-of-range writes are granted (so the requester moves on) but dropped.
    assign w_wr_en   = (w_a_gnt | w_b_gnt) && ({1'b0, w_wr_addr} < c_DEPTH);

    assign w_rd_in_range = ({1'b0, bus.lcd_addr} < c_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio_b <= 1'b0;
        end else if (w_a_gnt) begin
            r_prio_b <= 1'b1;
        end else if (w_b_gnt) begin
            r_prio_b <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer and registered read port. A same-edge write and read
    // of one entry returns the pre-write value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= c_SPACE;
            end
            r_lcd_data <= c_SPACE;
        end else begin
            if (w_wr_en) begin
                r_mem[w_wr_addr] <= w_wr_data;
            end
            r_lcd_data <= w_rd_in_range ? r_mem[bus.lcd_addr] : c_SPACE;
        end
    end

    // ------------------------------------------------------------------
    // Refresh FSM
    // ------------------------------------------------------------------
    assign w_timeout = (r_state == WAIT_ACK) && !bus.lcd_busy && (r_to_cnt == c_TO_LAST);
    assign w_done    = (r_state == WAIT_DONE) && !bus.lcd_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // Gating on busy also keeps the trigger off during the
                // driver's own power-on initialisation.
                if (r_dirty && !bus.lcd_busy) begin
                    w_state_nxt = TRIG;
                end
            end
            TRIG: begin
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.lcd_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = HOLDOFF;
                end
            end
            WAIT_DONE: begin
                if (w_done) begin
                    w_state_nxt = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Trigger is registered from the next state so it is high exactly
    // while the FSM sits in TRIG.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trg <= 1'b0;
        end else begin
            r_trg <= (w_state_nxt == TRIG);
        end
    end

    // Acknowledge timeout: cleared in TRIG, so WAIT_ACK lasts at most
    // BUSY_TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (r_state == TRIG) begin
            r_to_cnt <= '0;
        end else if (r_state == WAIT_ACK) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Hold-off counter reloads on every HOLDOFF entry and counts down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= '0;
        end else if ((w_state_nxt == HOLDOFF) && (r_state != HOLDOFF)) begin
            r_hold_cnt <= c_HOLD_LOAD;
        end else if ((r_state == HOLDOFF) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
        end
    end

    // Dirty: set by any in-range write (which beats the TRIG clear) and by
    // an unacknowledged trigger so the repaint is retried.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dirty <= 1'b1;
        end else if (w_wr_en || w_timeout) begin
            r_dirty <= 1'b1;
        end else if (r_state == TRIG) begin
            r_dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh_cnt <= 8'd0;
        end else if (w_done) begin
            r_refresh_cnt <= r_refresh_cnt + 8'd1;
        end
    end

    assign bus.a_gnt       = w_a_gnt;
    assign bus.b_gnt       = w_b_gnt;
    assign bus.lcd_trg     = r_trg;
    assign bus.lcd_data    = r_lcd_data;
    assign bus.dirty       = r_dirty;
    assign bus.refresh_cnt = r_refresh_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lcd_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_refresh_scheduler
// Description : Directed self-checking bench for lcd_refresh_scheduler.
//               Expected grants and read data are queued when stimulus is
//               driven and popped when the DUT responds; a local frame
//               buffer model supplies expected read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_refresh_scheduler;

    localparam int MEM_DEPTH = 80;
    localparam int ADDR_W    = 7;
    localparam int HOLD      = 20;
    localparam int TMO       = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_refresh_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    lcd_refresh_scheduler #(
        .MEM_DEPTH      (MEM_DEPTH),
        .ADDR_W         (ADDR_W),
        .HOLDOFF_CYCLES (HOLD),
        .BUSY_TIMEOUT   (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         n_tests   = 0;
    int         n_fail    = 0;
    int         trg_count = 0;
    logic [7:0] model [MEM_DEPTH];
    logic [7:0] rd_q  [$];
    logic [1:0] gnt_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Trigger monitor: counts pulses and checks none overlaps driver busy.
    always @(posedge clk) begin
        #1;
        if (bus.lcd_trg === 1'b1) begin
            trg_count++;
            chk("trg_while_busy", {31'd0, bus.lcd_busy}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trg(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.lcd_trg !== 1'b1 && n < max);
        chk("trg_seen", {31'd0, bus.lcd_trg}, 32'd1);
    endtask

    // Driver model: acknowledge a trigger, stay busy, then release.
    task automatic serve(input int busy_len);
        @(negedge clk);
        bus.lcd_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        bus.lcd_busy = 1'b0;
    endtask

    task automatic write1(input bit use_b, input int addr, input logic [7:0] data);
        @(negedge clk);
        if (use_b) begin
            bus.b_req  = 1'b1;
            bus.b_addr = addr[ADDR_W-1:0];
            bus.b_data = data;
        end else begin
            bus.a_req  = 1'b1;
            bus.a_addr = addr[ADDR_W-1:0];
            bus.a_data = data;
        end
        gnt_q.push_back(use_b ? 2'b01 : 2'b10);
        if (addr < MEM_DEPTH) model[addr] = data;
        #1;
        chk("single_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, {30'd0, gnt_q.pop_front()});
        tick();
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int addr);
        @(negedge clk);
        bus.lcd_addr = addr[ADDR_W-1:0];
        rd_q.push_back((addr < MEM_DEPTH) ? model[addr] : 8'h20);
        tick();
        chk(tag, {24'd0, bus.lcd_data}, {24'd0, rd_q.pop_front()});
    endtask

    initial begin
        int         n;
        int         t0;
        logic [1:0] exp_g;
        logic [7:0] a_d;
        logic [7:0] b_d;
        logic [7:0] exp_cnt;

        rst          = 1'b0;
        bus.a_req    = 1'b0;
        bus.a_addr   = '0;
        bus.a_data   = 8'h00;
        bus.b_req    = 1'b0;
        bus.b_addr   = '0;
        bus.b_data   = 8'h00;
        bus.lcd_busy = 1'b1;
        bus.lcd_addr = '0;
        for (int i = 0; i < MEM_DEPTH; i++) model[i] = 8'h20;

        // Reset state
        repeat (3) tick();
        chk("rst_dirty", {31'd0, bus.dirty}, 32'd1);
        chk("rst_trg", {31'd0, bus.lcd_trg}, 32'd0);
        chk("rst_cnt", {24'd0, bus.refresh_cnt}, 32'd0);
        chk("rst_lcd_data", {24'd0, bus.lcd_data}, 32'h20);

        // Driver busy with its power-on init for 1000 cycles
        @(negedge clk);
        rst = 1'b1;
        repeat (1000) tick();
        chk("init_no_trg", trg_count, 32'd0);
        @(negedge clk);
        bus.lcd_busy = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.lcd_trg !== 1'b1 && n < 5);
        chk("init_trg_seen", {31'd0, bus.lcd_trg}, 32'd1);
        chk("init_trg_within_2", {31'd0, (n <= 2)}, 32'd1);
        serve(4);
        tick();
        chk("init_single_pulse", trg_count, 32'd1);
        chk("init_dirty_clear", {31'd0, bus.dirty}, 32'd0);
        chk("init_cnt", {24'd0, bus.refresh_cnt}, 32'd1);

        // Contested writes: A addr 3, B addr 5
        for (int c = 0; c < 4; c++) gnt_q.push_back((c % 2 == 0) ? 2'b10 : 2'b01);
        a_d        = 8'h60;
        b_d        = 8'h70;
        bus.a_addr = 7'd3;
        bus.b_addr = 7'd5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.a_req  = 1'b1;
            bus.b_req  = 1'b1;
            bus.a_data = a_d;
            bus.b_data = b_d;
            #1;
            exp_g = gnt_q.pop_front();
            chk("rr_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, {30'd0, exp_g});
            if (exp_g[1]) begin
                model[3] = a_d;
                a_d      = a_d + 8'd1;
            end else begin
                model[5] = b_d;
                b_d      = b_d + 8'd1;
            end
        end
        @(negedge clk);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick();
        chk("rr_dirty", {31'd0, bus.dirty}, 32'd1);
        rd_chk("rr_buf3", 3);
        rd_chk("rr_buf5", 5);

        // Write during WAIT_DONE forces a follow-up refresh after hold-off
        wait_trg(100, n);
        @(negedge clk);
        bus.lcd_busy = 1'b1;
        repeat (3) @(negedge clk);
        write1(1'b0, 0, 8'h41);
        chk("wd_dirty", {31'd0, bus.dirty}, 32'd1);
        @(negedge clk);
        bus.lcd_busy = 1'b0;
        tick();
        chk("wd_cnt", {24'd0, bus.refresh_cnt}, 32'd2);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.lcd_trg !== 1'b1 && n < 200);
        chk("wd_retrig_spacing", n, HOLD + 1);
        serve(3);
        tick();
        chk("wd_cnt2", {24'd0, bus.refresh_cnt}, 32'd3);
        rd_chk("wd_buf0", 0);

        // Unacknowledged trigger times out and is retried
        write1(1'b1, 10, 8'h42);
        wait_trg(100, n);
        repeat (TMO) tick();
        chk("tmo_dirty_before", {31'd0, bus.dirty}, 32'd0);
        tick();
        chk("tmo_dirty_set", {31'd0, bus.dirty}, 32'd1);
        chk("tmo_cnt_kept", {24'd0, bus.refresh_cnt}, 32'd3);
        n = TMO + 1;
        do begin
            tick();
            n++;
        end while (bus.lcd_trg !== 1'b1 && n < 300);
        chk("tmo_retrig_spacing", n, HOLD + TMO + 2);
        serve(3);
        tick();
        chk("tmo_cnt_after", {24'd0, bus.refresh_cnt}, 32'd4);

        // Out-of-range write and reads
        write1(1'b0, 80, 8'h55);
        chk("oor_dirty", {31'd0, bus.dirty}, 32'd0);
        rd_chk("oor_rd79", 79);
        rd_chk("oor_rd16", 16);
        rd_chk("oor_rd10", 10);
        rd_chk("oor_rd100", 100);

        // Refresh counter wraps after 256 completed refreshes
        exp_cnt = 8'd4;
        for (int i = 0; i < 252; i++) begin
            write1(1'b0, 1, 8'(i));
            wait_trg(100, n);
            serve(2);
            tick();
            exp_cnt = exp_cnt + 8'd1;
            chk("loop_cnt", {24'd0, bus.refresh_cnt}, {24'd0, exp_cnt});
        end
        chk("cnt_wrap", {24'd0, bus.refresh_cnt}, 32'd0);
        rd_chk("loop_buf1", 1);

        // Reset in the middle of a refresh
        write1(1'b0, 2, 8'h33);
        wait_trg(100, n);
        @(negedge clk);
        bus.lcd_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < MEM_DEPTH; i++) model[i] = 8'h20;
        chk("midrst_dirty", {31'd0, bus.dirty}, 32'd1);
        chk("midrst_trg", {31'd0, bus.lcd_trg}, 32'd0);
        chk("midrst_cnt", {24'd0, bus.refresh_cnt}, 32'd0);
        chk("midrst_data", {24'd0, bus.lcd_data}, 32'h20);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
        t0  = trg_count;
        repeat (5) tick();
        chk("midrst_no_trg", trg_count, t0);
        rd_chk("midrst_buf2", 2);
        @(negedge clk);
        bus.lcd_busy = 1'b0;
        wait_trg(5, n);
        serve(2);
        tick();
        chk("midrst_cnt_after", {24'd0, bus.refresh_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
